mmio_perf_counter_bank: RTL and testbench

Parametrised bank of NUM_CNTR memory-mapped performance counters. Each counter has a programmable event select, a coherent snapshot copy and sticky overflow with a maskable interrupt. Replaces the fixed cycle/instruction counter pair in the CPU's MMIO region. The CPU memory stage decodes the bank's range, drives `en`, and muxes `rdata` into its load path.

---
 rtl/perf_cntr_pkg.sv | 31 +++
 rtl/perf_cntr_slice.sv | 93 +++++++++
 rtl/mmio_perf_counter_bank.sv | 153 +++++++++++++++
 tb/tb_mmio_perf_counter_bank.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_cntr_pkg.sv
// rtl/perf_cntr_pkg.sv - register map and CTRL bit positions for the performance counter bank
//
// Purpose: shared byte offsets of the bank's global registers, the per-counter
// window layout and the CTRL bit positions.
// Ports: none (package).

package perf_cntr_pkg;

   // Global registers
   localparam logic [31:0] OFS_CTRL        = 32'h0000_0000;
   localparam logic [31:0] OFS_OVF         = 32'h0000_0004;
   localparam logic [31:0] OFS_IRQ_MASK    = 32'h0000_0008;

   // Per-counter windows start at CNTR_BASE, one window every CNTR_STRIDE bytes
   localparam logic [31:0] CNTR_BASE       = 32'h0000_0040;
   localparam logic [31:0] CNTR_STRIDE     = 32'h0000_0020;
   localparam int          CNTR_STRIDE_LG2 = 5;

   // Offsets inside one counter window
   localparam logic [4:0]  SUB_LIVE_LO     = 5'h00;
   localparam logic [4:0]  SUB_LIVE_HI     = 5'h04;
   localparam logic [4:0]  SUB_SNAP_LO     = 5'h08;
   localparam logic [4:0]  SUB_SNAP_HI     = 5'h0C;
   localparam logic [4:0]  SUB_EVSEL       = 5'h10;

   // CTRL bits
   localparam int          CTRL_ENABLE_BIT = 0;
   localparam int          CTRL_CLEAR_BIT  = 1;
   localparam int          CTRL_SNAP_BIT   = 2;

endpackage

// File: rtl/perf_cntr_slice.sv
// rtl/perf_cntr_slice.sv - one performance counter with snapshot, event select and wrap detect
//
// Purpose: a single live counter, its snapshot copy and its event-select
// register. Reports a wrap pulse so the bank can set the sticky overflow bit.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_count_en        global CTRL enable
//   i_clear           clear-all pulse (beats live writes and increments)
//   i_snap            snapshot pulse (captures pre-increment, pre-clear value)
//   i_events          event strobe vector
//   i_wr_live_lo/hi   full-word writes to live low / high word
//   i_wr_evsel        write to event select
//   i_wdata           store data
//   o_live, o_snap    live and snapshot values
//   o_evsel           event select
//   o_wrap            counter wraps on this edge

module perf_cntr_slice #(
   parameter int         CNTR_WIDTH  = 48,
   parameter int         NUM_EVENTS  = 8,
   parameter logic [4:0] RESET_EVSEL = 5'd0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_count_en,
   input  logic                  i_clear,
   input  logic                  i_snap,
   input  logic [NUM_EVENTS-1:0] i_events,
   input  logic                  i_wr_live_lo,
   input  logic                  i_wr_live_hi,
   input  logic                  i_wr_evsel,
   input  logic [31:0]           i_wdata,
   output logic [CNTR_WIDTH-1:0] o_live,
   output logic [CNTR_WIDTH-1:0] o_snap,
   output logic [4:0]            o_evsel,
   output logic                  o_wrap
);

   // Bits of the counter that belong to the low 32-bit bus word
   localparam logic [CNTR_WIDTH-1:0] LO_MASK = CNTR_WIDTH'(64'hFFFF_FFFF);

   logic [CNTR_WIDTH-1:0] r_live;
   logic [CNTR_WIDTH-1:0] r_snap;
   logic [4:0]            r_evsel;

   logic [31:0]           w_events_ext;
   logic                  w_event;
   logic                  w_inc;
   logic [CNTR_WIDTH-1:0] w_wr_lo_val;
   logic [CNTR_WIDTH-1:0] w_wr_hi_val;

   // Zero-extending to 32 makes any evsel >= NUM_EVENTS pick a constant 0
   assign w_events_ext = 32'(i_events);
   assign w_event      = w_events_ext[r_evsel];

   // Clear and live writes both swallow this cycle's event
   assign w_inc  = i_count_en & w_event & ~i_clear & ~i_wr_live_lo & ~i_wr_live_hi;
   assign o_wrap = w_inc & (&r_live);

   // Word replacement keeps the other word; when the counter is 32 bits or
   // narrower the high-word value collapses to r_live, so hi writes vanish.
   assign w_wr_lo_val = (r_live & ~LO_MASK) | CNTR_WIDTH'(i_wdata);
   assign w_wr_hi_val = (r_live & LO_MASK) | CNTR_WIDTH'({i_wdata, 32'h0000_0000});

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_live  <= '0;
         r_snap  <= '0;
         r_evsel <= RESET_EVSEL;
      end else begin
         if (i_snap) begin
            r_snap <= r_live;
         end
         if (i_clear) begin
            r_live <= '0;
         end else if (i_wr_live_lo) begin
            r_live <= w_wr_lo_val;
         end else if (i_wr_live_hi) begin
            r_live <= w_wr_hi_val;
         end else if (w_inc) begin
            r_live <= r_live + CNTR_WIDTH'(1);
         end
         if (i_wr_evsel) begin
            r_evsel <= i_wdata[4:0];
         end
      end
   end

   assign o_live  = r_live;
   assign o_snap  = r_snap;
   assign o_evsel = r_evsel;

endmodule

// File: rtl/mmio_perf_counter_bank.sv
// rtl/mmio_perf_counter_bank.sv - memory-mapped bank of performance counters with overflow irq
//
// Purpose: address decode, CTRL/OVF/IRQ_MASK registers, registered read mux
// and interrupt for NUM_CNTR generated counter slices.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en           bank selected this cycle
//   i_addr         byte offset (bits [1:0] ignored)
//   i_wdata        store data
//   i_we           byte enables; only 4'hF performs a write
//   i_re           load request
//   o_rdata        registered load data, valid the cycle after i_re
//   i_events       one-cycle event strobes
//   o_irq          registered |(ovf & irq_mask)

module mmio_perf_counter_bank
   import perf_cntr_pkg::*;
#(
   parameter int NUM_CNTR   = 4,
   parameter int CNTR_WIDTH = 48,
   parameter int NUM_EVENTS = 8,
   parameter int ADDR_W     = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic [31:0]           i_wdata,
   input  logic [3:0]            i_we,
   input  logic                  i_re,
   output logic [31:0]           o_rdata,
   input  logic [NUM_EVENTS-1:0] i_events,
   output logic                  o_irq
);

   logic                r_enable;
   logic [NUM_CNTR-1:0] r_ovf;
   logic [NUM_CNTR-1:0] r_mask;
   logic                r_irq;
   logic [31:0]         r_rdata;

   logic [31:0]         w_off;
   logic [31:0]         w_rel;
   logic [31:0]         w_cidx;
   logic [4:0]          w_sub;
   logic                w_in_bank;
   logic                w_wr;
   logic                w_rd;
   logic                w_ctrl_wr;
   logic                w_clear;
   logic                w_snap;
   logic [NUM_CNTR-1:0] w_ovf_clr;
   logic [NUM_CNTR-1:0] w_wrap;
   logic [31:0]         w_rd_val;

   logic [CNTR_WIDTH-1:0] w_live  [NUM_CNTR];
   logic [CNTR_WIDTH-1:0] w_snapv [NUM_CNTR];
   logic [4:0]            w_evsel [NUM_CNTR];

   // Word-aligned offset; the two low address bits are dropped here
   assign w_off     = 32'(i_addr) & 32'hFFFF_FFFC;
   assign w_rel     = w_off - CNTR_BASE;
   assign w_cidx    = w_rel >> CNTR_STRIDE_LG2;
   assign w_sub     = w_rel[4:0];
   assign w_in_bank = (w_off >= CNTR_BASE) && (w_cidx < NUM_CNTR);

   // Partial-width stores are dropped entirely
   assign w_wr      = i_en & (i_we == 4'hF);
   assign w_rd      = i_en & i_re;

   assign w_ctrl_wr = w_wr & (w_off == OFS_CTRL);
   assign w_clear   = w_ctrl_wr & i_wdata[CTRL_CLEAR_BIT];
   assign w_snap    = w_ctrl_wr & i_wdata[CTRL_SNAP_BIT];
   assign w_ovf_clr = (w_wr && (w_off == OFS_OVF)) ? i_wdata[NUM_CNTR-1:0] : '0;

   for (genvar g = 0; g < NUM_CNTR; g++) begin : g_cntr
      logic w_sel;
      assign w_sel = w_wr & w_in_bank & (w_cidx == 32'(g));

      perf_cntr_slice #(
         .CNTR_WIDTH  (CNTR_WIDTH),
         .NUM_EVENTS  (NUM_EVENTS),
         .RESET_EVSEL (5'(g % NUM_EVENTS))
      ) u_slice (
         .i_clk        (i_clk),
         .i_rst        (i_rst),
         .i_count_en   (r_enable),
         .i_clear      (w_clear),
         .i_snap       (w_snap),
         .i_events     (i_events),
         .i_wr_live_lo (w_sel & (w_sub == SUB_LIVE_LO)),
         .i_wr_live_hi (w_sel & (w_sub == SUB_LIVE_HI)),
         .i_wr_evsel   (w_sel & (w_sub == SUB_EVSEL)),
         .i_wdata      (i_wdata),
         .o_live       (w_live[g]),
         .o_snap       (w_snapv[g]),
         .o_evsel      (w_evsel[g]),
         .o_wrap       (w_wrap[g])
      );
   end

   // Read mux works on current register values, so a same-cycle write is not seen
   always_comb begin
      w_rd_val = '0;
      if (w_off == OFS_CTRL) begin
         w_rd_val = 32'(r_enable);
      end else if (w_off == OFS_OVF) begin
         w_rd_val = 32'(r_ovf);
      end else if (w_off == OFS_IRQ_MASK) begin
         w_rd_val = 32'(r_mask);
      end else if (w_in_bank) begin
         for (int i = 0; i < NUM_CNTR; i++) begin
            if (w_cidx == 32'(i)) begin
               case (w_sub)
                  SUB_LIVE_LO: w_rd_val = 32'(w_live[i]);
                  SUB_LIVE_HI: w_rd_val = 32'(64'(w_live[i]) >> 32);
                  SUB_SNAP_LO: w_rd_val = 32'(w_snapv[i]);
                  SUB_SNAP_HI: w_rd_val = 32'(64'(w_snapv[i]) >> 32);
                  SUB_EVSEL:   w_rd_val = 32'(w_evsel[i]);
                  default:     w_rd_val = '0;
               endcase
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_enable <= 1'b1;
         r_ovf    <= '0;
         r_mask   <= '0;
         r_irq    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         if (w_ctrl_wr) begin
            r_enable <= i_wdata[CTRL_ENABLE_BIT];
         end
         // A wrap on the same edge as its W1C keeps the bit set
         r_ovf <= (r_ovf & ~w_ovf_clr) | w_wrap;
         if (w_wr && (w_off == OFS_IRQ_MASK)) begin
            r_mask <= i_wdata[NUM_CNTR-1:0];
         end
         r_irq <= |(r_ovf & r_mask);
         if (w_rd) begin
            r_rdata <= w_rd_val;
         end
      end
   end

   assign o_rdata = r_rdata;
   assign o_irq   = r_irq;

endmodule

// File: tb/tb_mmio_perf_counter_bank.sv
// tb/tb_mmio_perf_counter_bank.sv - self-checking bench for the performance counter bank

module tb_mmio_perf_counter_bank;

   localparam int NC = 4;
   localparam int CW = 48;
   localparam int NE = 8;
   localparam int AW = 12;
   localparam longint unsigned MAXV = (64'd1 << CW) - 64'd1;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          en    = 1'b0;
   logic          re    = 1'b0;
   logic [AW-1:0] addr  = '0;
   logic [31:0]   wdata = '0;
   logic [3:0]    we    = '0;
   logic [NE-1:0] ev    = 8'h01;
   logic [31:0]   rdata;
   logic          irq;

   int checks = 0;
   int errors = 0;
   int since_rel = 0;

   longint unsigned m_live [NC];
   longint unsigned m_snap [NC];
   int              m_evsel[NC];
   logic [NC-1:0]   m_ovf;
   logic [NC-1:0]   m_mask;
   logic            m_en;
   logic [31:0]     m_rdata;
   logic            m_irq;

   mmio_perf_counter_bank #(
      .NUM_CNTR(NC), .CNTR_WIDTH(CW), .NUM_EVENTS(NE), .ADDR_W(AW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_addr(addr), .i_wdata(wdata),
      .i_we(we), .i_re(re), .o_rdata(rdata), .i_events(ev), .o_irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NC; i++) begin
         m_live[i]  = 0;
         m_snap[i]  = 0;
         m_evsel[i] = i % NE;
      end
      m_ovf = '0; m_mask = '0; m_en = 1'b1; m_rdata = '0; m_irq = 1'b0;
   endtask

   function automatic logic [31:0] m_read(input logic [AW-1:0] a);
      logic [31:0] off;
      int unsigned idx, sub;
      off = 32'(a) & 32'hFFFF_FFFC;
      if (off == 0) return {31'd0, m_en};
      if (off == 4) return 32'(m_ovf);
      if (off == 8) return 32'(m_mask);
      if (off < 32'h40) return 32'd0;
      idx = (off - 32'h40) / 32;
      sub = (off - 32'h40) % 32;
      if (idx >= NC) return 32'd0;
      case (sub)
         0:  return 32'(m_live[idx]);
         4:  return 32'(m_live[idx] >> 32);
         8:  return 32'(m_snap[idx]);
         12: return 32'(m_snap[idx] >> 32);
         16: return 32'(m_evsel[idx]);
         default: return 32'd0;
      endcase
   endfunction

   // Reference behaviour of one rising edge, from the pre-edge inputs and state
   task automatic model_edge();
      logic [31:0]     off;
      logic            wr, clr, snp, irq_n, evb;
      logic [NC-1:0]   set, w1c;
      longint unsigned nv;
      int unsigned     base;
      if (rst) begin
         m_reset();
         return;
      end
      irq_n = |(m_ovf & m_mask);
      if (en && re) m_rdata = m_read(addr);
      wr  = en && (we == 4'hF);
      off = 32'(addr) & 32'hFFFF_FFFC;
      clr = wr && (off == 0) && wdata[1];
      snp = wr && (off == 0) && wdata[2];
      set = '0;
      w1c = '0;
      for (int i = 0; i < NC; i++) begin
         base = 32'h40 + 32 * i;
         if (m_evsel[i] < NE) evb = ev[m_evsel[i]];
         else evb = 1'b0;
         nv = m_live[i];
         if (clr) nv = 0;
         else if (wr && off == base)
            nv = (((m_live[i] >> 32) << 32) | 64'(wdata)) & MAXV;
         else if (wr && off == base + 4)
            nv = ((64'(wdata) << 32) | (m_live[i] & 64'hFFFF_FFFF)) & MAXV;
         else if (m_en && evb) begin
            if (m_live[i] == MAXV) set[i] = 1'b1;
            nv = (m_live[i] + 1) & MAXV;
         end
         if (snp) m_snap[i] = m_live[i];
         m_live[i] = nv;
         if (wr && off == base + 16) m_evsel[i] = int'(wdata[4:0]);
      end
      if (wr && off == 4) w1c = wdata[NC-1:0];
      m_ovf = (m_ovf & ~w1c) | set;
      if (wr && off == 8) m_mask = wdata[NC-1:0];
      if (wr && off == 0) m_en = wdata[0];
      m_irq = irq_n;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      if (rst) since_rel = 0;
      else since_rel++;
      #1;
   endtask

   task automatic bus_idle();
      en = 1'b0; re = 1'b0; we = 4'h0;
   endtask

   task automatic wrb(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
      en = 1'b1; re = 1'b0; we = b; addr = a; wdata = d;
      tick();
      bus_idle();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      wrb(a, d, 4'hF);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      en = 1'b1; re = 1'b1; we = 4'h0; addr = a;
      tick();
      bus_idle();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int k;
      int subs[6];
      subs = '{0, 4, 8, 12, 16, 20};
      k = $urandom_range(0, 9);
      if (k < 3) return AW'(4 * k);
      if (k == 3) return AW'($urandom);
      return AW'(32'h40 + 32 * $urandom_range(0, 5) + subs[$urandom_range(0, 5)]
                 + $urandom_range(0, 3));
   endfunction

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'($urandom_range(0, 40));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [9:0]  pat;
      logic [31:0] v;
      int          n0;

      m_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);

      // Counter 0 counts cycles from reset release
      idle(10);
      n0 = since_rel;
      rd(12'h040);
      chk("cycle_count", rdata, 32'(n0));
      chk("cycle_count_10", rdata, 32'd10);
      rd(12'h000);
      chk("ctrl_reset", rdata, 32'h1);
      rd(12'h070);
      chk("evsel1_reset", rdata, 32'd1);
      rd(12'h090);
      chk("evsel2_reset", rdata, 32'd2);

      // Clear-all, then 7 instruction strobes in 10 cycles
      wr(12'h000, 32'h3);
      pat = 10'b1101101101;
      for (int k = 0; k < 10; k++) begin
         ev[1] = pat[k];
         tick();
      end
      ev[1] = 1'b0;
      rd(12'h060);
      chk("instr_count", rdata, 32'd7);
      rd(12'h040);
      chk("cycles_after_clear", rdata, 32'd11);
      chk("cycles_after_clear_m", rdata, m_rdata);

      // Overflow, irq and W1C
      wr(12'h008, 32'h1);
      wr(12'h044, 32'h0000_FFFF);
      wr(12'h040, 32'hFFFF_FFFF);
      tick();
      chk("irq_same_edge", {31'd0, irq}, 32'd0);
      tick();
      chk("irq_next", {31'd0, irq}, 32'd1);
      rd(12'h004);
      chk("ovf_set", rdata, 32'h1);
      rd(12'h044);
      chk("live0_hi_wrapped", rdata, 32'd0);
      rd(12'h040);
      chk("live0_lo_wrapped", rdata, m_rdata);
      wr(12'h004, 32'h1);
      chk("irq_at_w1c", {31'd0, irq}, 32'd1);
      tick();
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      rd(12'h004);
      chk("ovf_cleared", rdata, 32'h0);

      // W1C on the same edge as a new wrap: set wins
      wr(12'h044, 32'h0000_FFFF);
      wr(12'h040, 32'hFFFF_FFFF);
      wr(12'h004, 32'h1);
      rd(12'h004);
      chk("ovf_set_wins", rdata, 32'h1);
      wr(12'h004, 32'h1);
      wr(12'h008, 32'h0);

      // Snapshot plus clear captures the pre-clear value
      wr(12'h040, 32'h123);
      wr(12'h000, 32'h7);
      rd(12'h048);
      chk("snap0_lo", rdata, 32'h123);
      rd(12'h04C);
      chk("snap0_hi", rdata, 32'h0);
      rd(12'h040);
      chk("live0_restart", rdata, 32'd2);
      rd(12'h068);
      chk("snap1_lo", rdata, m_rdata);

      // Disabled: frozen counters
      wr(12'h000, 32'h0);
      rd(12'h040);
      chk("frozen_a", rdata, m_rdata);
      v = m_rdata;
      idle(20);
      rd(12'h040);
      chk("frozen_b", rdata, v);

      // Out-of-range evsel, partial writes ignored, unmapped reads
      wr(12'h000, 32'h1);
      wr(12'h050, 32'd31);
      rd(12'h040);
      v = m_rdata;
      chk("evsel31_a", rdata, v);
      idle(5);
      wrb(12'h050, 32'd5, 4'h1);
      wrb(12'h040, 32'h0, 4'h3);
      rd(12'h040);
      chk("evsel31_b", rdata, v);
      rd(12'h050);
      chk("evsel_sb_ignored", rdata, 32'd31);
      wr(12'h100, 32'hDEAD_BEEF);
      rd(12'h100);
      chk("unmapped_cidx", rdata, 32'd0);
      rd(12'h054);
      chk("unmapped_sub", rdata, 32'd0);
      rd(12'h00C);
      chk("unmapped_glob", rdata, 32'd0);
      wr(12'h050, 32'd0);

      // Reset mid-operation drops the pending read
      wr(12'h080, 32'd500);
      idle(2);
      rd(12'h080);
      chk("live2_500", rdata, 32'd500);
      en = 1'b1; re = 1'b1; addr = 12'h080; rst = 1'b1;
      tick();
      bus_idle();
      rst = 1'b0;
      chk("rst_rdata", rdata, 32'd0);
      rd(12'h080);
      chk("rst_live2", rdata, 32'd0);
      rd(12'h090);
      chk("rst_evsel2", rdata, 32'd2);
      rd(12'h000);
      chk("rst_ctrl", rdata, 32'h1);
      chk("rst_irq", {31'd0, irq}, 32'd0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         ev = NE'($urandom);
         en = ($urandom_range(0, 3) != 0);
         re = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       we = 4'h0;
            1:       we = 4'($urandom);
            default: we = 4'hF;
         endcase
         addr  = rand_addr();
         wdata = rand_data();
         rst   = ($urandom_range(0, 149) == 0);
         tick();
         chk("rand_rdata", rdata, m_rdata);
         chk("rand_irq", {31'd0, irq}, {31'd0, m_irq});
      end
      rst = 1'b0;
      bus_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
